morse_sequencer: RTL and testbench
==================================

# morse_sequencer

Parametrised Morse-style tone sequencer that drives the board buzzer.
- Plays up to N_CHARS characters. Each character is a variable-length string of short/long symbols.
- Symbols are separated by an intra-symbol silence; characters are followed by an inter-character gap.
- All operands are snapshotted at start. A start/busy/done handshake and an abort input are provided, so the block sits behind the key-debounce and input-register logic as a reusable output stage.

## Interface
Parameters:
- N_CHARS, 8, number of character slots.
- SYM_BITS, 5, maximum symbols per character.
- TONE_PERIOD, 75850, clocks per tone cycle; must be even and ≥ 2.
- SHORT_CYC, 158, tone periods per short symbol; must be ≥ 2.
- LONG_CYC, 316, tone periods per long symbol; must be ≥ 2.
- GAP_CYC, 120, silent tone periods after each character; must be ≥ 1.
- Derived constants: LW = $clog2(SYM_BITS+1); CW = $clog2(N_CHARS+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  stop playback immediately.
- chars  in  N_CHARS*SYM_BITS  character i occupies chars[i*SYM_BITS +: SYM_BITS]; symbol bit 1 = long, 0 = short.
- lens  in  N_CHARS*LW  per-character symbol count; 0 = word space (gap only).
- count  in  CW  number of characters to play, 0..N_CHARS.
- loop  in  1  repeat the sequence; present only with MORSE_LOOP_EN.
- buzzer  out  1  square-wave drive, registered.
- busy  out  1  playback in progress.
- done  out  1  one-cycle completion pulse.
- char_idx  out  CW  index of the character currently playing.

## Operation
- States: IDLE, SYM, GAP, FIN.
- IDLE:
  - On start with count ≥ 1: latch chars, lens and count.
  - Clamp count to N_CHARS and each len to SYM_BITS.
  - Set char_idx = 0 and the symbol pointer to the field MSB.
  - Go to SYM, or to GAP if lens[0] = 0.
- IDLE, start with count = 0: go to FIN; no tone and no busy.
- SYM: a phase counter runs 0..TONE_PERIOD-1. A period counter runs 0..P-1, with P = LONG_CYC for bit 1 and SHORT_CYC for bit 0.
  - buzzer = 1 when period counter < P/2 (floor) and phase < TONE_PERIOD/2; otherwise 0.
  - At the end of the last period: if more symbols remain in the character, advance the symbol pointer toward the LSB; otherwise go to GAP.
- GAP: buzzer 0 for GAP_CYC periods.
  - Then increment char_idx and go to SYM (or GAP again if that character's len = 0).
  - After the last character, go to FIN.
- FIN: assert done for one cycle, then return to IDLE.
- Live chars, lens and count changes during playback have no effect.
- abort in SYM or GAP: next state IDLE, buzzer 0, busy 0, no done pulse. abort in IDLE or FIN has no effect (a done pulse in FIN still completes).
- start while busy is ignored. If abort and start occur in the same cycle, abort wins.
- rst overrides everything.

## Timing
- Reset values: buzzer 0, busy 0, done 0, char_idx 0, state IDLE, all counters 0.
- Call the start-sampling edge cycle 0.
  - busy = 1 from cycle 1.
  - buzzer first high in cycle 2; registered output, 1-cycle lag behind state/counters.
- Character duration = (sum of its symbols' P + GAP_CYC) × TONE_PERIOD cycles. Sequence total T = sum over played characters.
- busy is high in cycles 1..T. done = 1 and busy = 0 in cycle T+1.
- A start is accepted again from cycle T+2.
- For count = 0: done in cycle 1, busy never high.
- Abort at cycle k: busy and buzzer are 0 from cycle k+1.
- Counter widths: sized to hold TONE_PERIOD-1 and max(LONG_CYC, SHORT_CYC, GAP_CYC)-1. Wrap exactly at terminal count; no overflow.

## Configuration
- MORSE_LOOP_EN defined:
  - The loop port exists.
  - At the end of the last character's GAP with loop = 1: restart at char_idx 0 with the latched data. No FIN, no done pulse, busy stays 1.
  - loop is sampled at each sequence end. Abort stops the loop.
- MORSE_LOOP_EN undefined: no loop port; every sequence ends in FIN.

## Test plan
Test parameters for all scenarios: TONE_PERIOD=4, SHORT_CYC=2, LONG_CYC=4, GAP_CYC=3, N_CHARS=2, SYM_BITS=3.
- Reset: assert rst for 3 cycles mid-playback -> next cycle buzzer=0, busy=0, done=0, char_idx=0.
- Basic sequence: chars char0=3'b101, len0=3, len1=0, count=2, start at cycle 0 -> busy cycles 1..64; 10 buzzer-high cycles total (pairs at a 4-cycle pitch); char_idx=1 during cycles 53..64; done=1 only in cycle 65.
- count=0 start -> done in cycle 1, busy never 1, buzzer stays 0.
- Latch and ignore: modify chars and pulse start at cycle 20 of the basic sequence -> waveform identical to the basic-sequence case.
- Abort at cycle 30 together with start -> busy=0 and buzzer=0 from cycle 31, no done pulse, next start accepted.
- MORSE_LOOP_EN, loop=1 for the basic sequence -> char_idx returns to 0 at cycle 65, no done pulse; loop=0 from cycle 70 -> done at cycle 129.

Source files
------------

// File: rtl/morse_sequencer.sv
// morse_sequencer: snapshots up to N_CHARS short/long symbol strings and plays them as a
// gated square wave on the buzzer. Define MORSE_LOOP_EN to add the loop input (sequence repeat).
module morse_sequencer #(
  parameter int  N_CHARS     = 8,
  parameter int  SYM_BITS    = 5,
  parameter int  TONE_PERIOD = 75850,
  parameter int  SHORT_CYC   = 158,
  parameter int  LONG_CYC    = 316,
  parameter int  GAP_CYC     = 120,
  localparam int LW          = $clog2(SYM_BITS + 1),
  localparam int CW          = $clog2(N_CHARS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [N_CHARS*SYM_BITS-1:0] chars,
  input  logic [N_CHARS*LW-1:0]       lens,
  input  logic [CW-1:0]               count,
`ifdef MORSE_LOOP_EN
  input  logic                        loop,
`endif
  output logic                        buzzer,
  output logic                        busy,
  output logic                        done,
  output logic [CW-1:0]               char_idx
);

  localparam int MAX_SYM_CYC = (LONG_CYC > SHORT_CYC) ? LONG_CYC : SHORT_CYC;
  localparam int MAX_CYC     = (MAX_SYM_CYC > GAP_CYC) ? MAX_SYM_CYC : GAP_CYC;
  localparam int PHW         = $clog2(TONE_PERIOD);
  localparam int PRW         = $clog2(MAX_CYC);
  localparam int PW          = (SYM_BITS > 1) ? $clog2(SYM_BITS) : 1;
  localparam int IW          = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;

  localparam logic [PHW-1:0] PH_LAST    = PHW'(TONE_PERIOD - 1);
  localparam logic [PHW-1:0] PH_HALF    = PHW'(TONE_PERIOD / 2);
  localparam logic [PRW-1:0] LONG_LAST  = PRW'(LONG_CYC - 1);
  localparam logic [PRW-1:0] SHORT_LAST = PRW'(SHORT_CYC - 1);
  localparam logic [PRW-1:0] GAP_LAST   = PRW'(GAP_CYC - 1);
  localparam logic [PRW-1:0] LONG_HALF  = PRW'(LONG_CYC / 2);
  localparam logic [PRW-1:0] SHORT_HALF = PRW'(SHORT_CYC / 2);
  localparam logic [PW-1:0]  PTR_MSB    = PW'(SYM_BITS - 1);
  localparam logic [LW-1:0]  LEN_MAX    = LW'(SYM_BITS);
  localparam logic [CW-1:0]  CNT_MAX    = CW'(N_CHARS);

  typedef enum logic [1:0] {IDLE, SYM, GAP, FIN} state_e;

  state_e               state_q, state_d;
  logic [PHW-1:0]       phase_q, phase_d;
  logic [PRW-1:0]       per_q, per_d;
  logic [PW-1:0]        sym_ptr_q, sym_ptr_d;
  logic [CW-1:0]        char_idx_q, char_idx_d;
  logic                 buzzer_q, buzzer_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [SYM_BITS-1:0]  chars_q [N_CHARS];
  logic [LW-1:0]        lens_q  [N_CHARS];
  logic [CW-1:0]        count_q;

  logic [IW-1:0]        cur_idx, nxt_idx;
  logic [LW-1:0]        nxt_len;
  logic [PW-1:0]        last_ptr;
  logic [PRW-1:0]       per_last, per_half;
  logic                 cur_bit, last_sym, last_char, phase_end, period_end;
  logic                 accept, loop_req;

  // NOTE: the operand snapshot has no reset; it is only read after a start has loaded it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE && accept) begin
      count_q <= (count > CNT_MAX) ? CNT_MAX : count;
      for (int i = 0; i < N_CHARS; i++) begin
        chars_q[i] <= chars[i*SYM_BITS +: SYM_BITS];
        lens_q[i]  <= (lens[i*LW +: LW] > LEN_MAX) ? LEN_MAX : lens[i*LW +: LW];
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    cur_idx    = char_idx_q[IW-1:0];
    cur_bit    = chars_q[cur_idx][sym_ptr_q];
    // Symbols play from the field MSB down; the last one sits len positions below the top.
    last_ptr   = PW'(SYM_BITS - int'(lens_q[cur_idx]));
    last_sym   = (sym_ptr_q == last_ptr);
    last_char  = ((char_idx_q + CW'(1)) == count_q);
    nxt_idx    = last_char ? '0 : IW'(char_idx_q + CW'(1));
    nxt_len    = lens_q[nxt_idx];
    per_last   = (state_q == GAP) ? GAP_LAST : (cur_bit ? LONG_LAST : SHORT_LAST);
    per_half   = cur_bit ? LONG_HALF : SHORT_HALF;
    phase_end  = (phase_q == PH_LAST);
    period_end = phase_end && (per_q == per_last);
    accept     = start && !abort;
`ifdef MORSE_LOOP_EN
    loop_req   = loop;
`else
    loop_req   = 1'b0;
`endif

    state_d    = state_q;
    phase_d    = phase_q;
    per_d      = per_q;
    sym_ptr_d  = sym_ptr_q;
    char_idx_d = char_idx_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          phase_d    = '0;
          per_d      = '0;
          sym_ptr_d  = PTR_MSB;
          char_idx_d = '0;
          if (count == '0)           state_d = FIN;
          else if (lens[LW-1:0] == '0) state_d = GAP;
          else                       state_d = SYM;
        end
      end
      SYM, GAP: begin
        phase_d = phase_end ? '0 : phase_q + PHW'(1);
        if (phase_end) per_d = (per_q == per_last) ? '0 : per_q + PRW'(1);
        if (period_end) begin
          if (state_q == SYM) begin
            if (!last_sym) sym_ptr_d = sym_ptr_q - PW'(1);
            else           state_d   = GAP;
          end else if (!last_char || loop_req) begin
            char_idx_d = CW'(nxt_idx);
            sym_ptr_d  = PTR_MSB;
            state_d    = (nxt_len == '0) ? GAP : SYM;
          end else begin
            state_d = FIN;
          end
        end
        if (abort) begin
          state_d = IDLE;
          phase_d = '0;
          per_d   = '0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d == SYM) || (state_d == GAP);
    done_d   = (state_d == FIN);
    // Tone follows the current counters, so the pin lags state by one cycle.
    buzzer_d = (state_q == SYM) && !abort && (per_q < per_half) && (phase_q < PH_HALF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      per_q      <= '0;
      sym_ptr_q  <= '0;
      char_idx_q <= '0;
      buzzer_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      per_q      <= per_d;
      sym_ptr_q  <= sym_ptr_d;
      char_idx_q <= char_idx_d;
      buzzer_q   <= buzzer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign buzzer   = buzzer_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign char_idx = char_idx_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer: a cycle model pushes the expected buzzer/busy/done/
// char_idx stream per start, and each scenario pops and compares one entry per clock.
module tb_morse_sequencer;

  localparam int N_CHARS = 2;
  localparam int SYM_BITS = 3;
  localparam int TP = 4;
  localparam int SC = 2;
  localparam int LC = 4;
  localparam int GC = 3;
  localparam int LW = $clog2(SYM_BITS + 1);
  localparam int CW = $clog2(N_CHARS + 1);

  localparam logic [N_CHARS*SYM_BITS-1:0] BASIC_CH = 6'b000_101;
  localparam logic [N_CHARS*LW-1:0]       BASIC_LN = 4'b00_11;

  logic                        clk = 1'b0;
  logic                        rst, start, abort;
  logic [N_CHARS*SYM_BITS-1:0] chars;
  logic [N_CHARS*LW-1:0]       lens;
  logic [CW-1:0]               count;
`ifdef MORSE_LOOP_EN
  logic                        loop;
`endif
  logic                        buzzer, busy, done;
  logic [CW-1:0]               char_idx;

  typedef struct packed {
    logic          buz;
    logic          busy;
    logic          done;
    logic          idx_chk;
    logic [CW-1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  morse_sequencer #(
    .N_CHARS(N_CHARS), .SYM_BITS(SYM_BITS), .TONE_PERIOD(TP),
    .SHORT_CYC(SC), .LONG_CYC(LC), .GAP_CYC(GC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .chars(chars),
    .lens(lens),
    .count(count),
`ifdef MORSE_LOOP_EN
    .loop(loop),
`endif
    .buzzer(buzzer),
    .busy(busy),
    .done(done),
    .char_idx(char_idx)
  );

  function automatic exp_t mk(input logic b, input logic bz, input logic d, input logic chk,
                              input logic [CW-1:0] idx);
    exp_t e;
    e = '{buz: b, busy: bz, done: d, idx_chk: chk, idx: idx};
    return e;
  endfunction

  // Expected stream for cycles 1..T+1 after a start, built from the timing description.
  task automatic push_model(input logic [N_CHARS*SYM_BITS-1:0] ch,
                            input logic [N_CHARS*LW-1:0] ln, input int cnt_in, input int passes);
    int   cnt, len, plen;
    logic bitv, prev, tone;
    cnt  = (cnt_in > N_CHARS) ? N_CHARS : cnt_in;
    prev = 1'b0;
    if (cnt == 0) begin
      sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, '0));
      return;
    end
    for (int ps = 0; ps < passes; ps++) begin
      for (int c = 0; c < cnt; c++) begin
        len = int'(ln[c*LW +: LW]);
        if (len > SYM_BITS) len = SYM_BITS;
        for (int s = 0; s < len; s++) begin
          bitv = ch[c*SYM_BITS + SYM_BITS - 1 - s];
          plen = bitv ? LC : SC;
          for (int p = 0; p < plen; p++) begin
            for (int ph = 0; ph < TP; ph++) begin
              tone = (p < plen / 2) && (ph < TP / 2);
              sb.push_back(mk(prev, 1'b1, 1'b0, 1'b1, CW'(c)));
              prev = tone;
            end
          end
        end
        for (int g = 0; g < GC * TP; g++) begin
          sb.push_back(mk(prev, 1'b1, 1'b0, 1'b1, CW'(c)));
          prev = 1'b0;
        end
      end
    end
    sb.push_back(mk(prev, 1'b0, 1'b1, 1'b0, '0));
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Drives start in the current cycle (cycle 0) and leaves the bench in cycle 1.
  task automatic launch(input logic [N_CHARS*SYM_BITS-1:0] ch,
                        input logic [N_CHARS*LW-1:0] ln, input logic [CW-1:0] cnt);
    chars = ch;
    lens  = ln;
    count = cnt;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({buzzer, busy, done, char_idx} !== '0) begin
      errors++;
      $display("FAIL reset_state got buz/busy/done/idx=%b%b%b/%0d want 000/0", buzzer, busy, done, char_idx);
    end
    launch(BASIC_CH, BASIC_LN, 2'd2);
    repeat (9) tick();
    checks++;
    if (busy !== 1'b1 || char_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_midplay cyc=%0d got busy=%b idx=%0d want busy=1 idx=0", cyc, busy, char_idx);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rst = 1'b0;
      tick();
      checks++;
      if ({buzzer, busy, done, char_idx} !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got buz/busy/done/idx=%b%b%b/%0d want 000/0", cyc, buzzer, busy, done, char_idx);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   highs = 0;
    push_model(BASIC_CH, BASIC_LN, 2, 1);
    launch(BASIC_CH, BASIC_LN, 2'd2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (buzzer === 1'b1) highs++;
      checks++;
      if ({buzzer, busy, done} !== {e.buz, e.busy, e.done} || (e.idx_chk && char_idx !== e.idx)) begin
        errors++;
        $display("FAIL basic cyc=%0d got buz/busy/done/idx=%b%b%b/%0d want %b%b%b/%0d", cyc, buzzer, busy, done, char_idx, e.buz, e.busy, e.done, e.idx);
      end
      tick();
    end
    checks++;
    if (highs !== 10) begin
      errors++;
      $display("FAIL basic_highs got %0d buzzer-high cycles want 10", highs);
    end
  endtask

  task automatic test_count_zero();
    exp_t e;
    push_model(BASIC_CH, BASIC_LN, 0, 1);
    repeat (3) sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
    launch(BASIC_CH, BASIC_LN, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({buzzer, busy, done} !== {e.buz, e.busy, e.done}) begin
        errors++;
        $display("FAIL count_zero cyc=%0d got buz/busy/done=%b%b%b want %b%b%b", cyc, buzzer, busy, done, e.buz, e.busy, e.done);
      end
      tick();
    end
  endtask

  task automatic test_latch_ignore();
    exp_t e;
    push_model(BASIC_CH, BASIC_LN, 2, 1);
    launch(BASIC_CH, BASIC_LN, 2'd2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({buzzer, busy, done} !== {e.buz, e.busy, e.done} || (e.idx_chk && char_idx !== e.idx)) begin
        errors++;
        $display("FAIL latch_ignore cyc=%0d got buz/busy/done/idx=%b%b%b/%0d want %b%b%b/%0d", cyc, buzzer, busy, done, char_idx, e.buz, e.busy, e.done, e.idx);
      end
      start = (cyc == 20);
      if (cyc == 20) begin
        chars = 6'b110_010;
        lens  = 4'b01_01;
        count = 2'd1;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    exp_t e;
    push_model(BASIC_CH, BASIC_LN, 2, 1);
    launch(BASIC_CH, BASIC_LN, 2'd2);
    while (cyc <= 30) begin
      e = sb.pop_front();
      checks++;
      if ({buzzer, busy, done} !== {e.buz, e.busy, e.done} || char_idx !== e.idx) begin
        errors++;
        $display("FAIL abort_pre cyc=%0d got buz/busy/done/idx=%b%b%b/%0d want %b%b%b/%0d", cyc, buzzer, busy, done, char_idx, e.buz, e.busy, e.done, e.idx);
      end
      if (cyc == 30) begin
        abort = 1'b1;
        start = 1'b1;
      end
      tick();
    end
    abort = 1'b0;
    start = 1'b0;
    sb.delete();
    repeat (8) sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({buzzer, busy, done} !== {e.buz, e.busy, e.done}) begin
        errors++;
        $display("FAIL abort_post cyc=%0d got buz/busy/done=%b%b%b want %b%b%b", cyc, buzzer, busy, done, e.buz, e.busy, e.done);
      end
      tick();
    end
    push_model(BASIC_CH, BASIC_LN, 2, 1);
    launch(BASIC_CH, BASIC_LN, 2'd2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({buzzer, busy, done} !== {e.buz, e.busy, e.done} || (e.idx_chk && char_idx !== e.idx)) begin
        errors++;
        $display("FAIL abort_restart cyc=%0d got buz/busy/done/idx=%b%b%b/%0d want %b%b%b/%0d", cyc, buzzer, busy, done, char_idx, e.buz, e.busy, e.done, e.idx);
      end
      tick();
    end
  endtask

  // Count above N_CHARS clamps; the second sequence starts in the first cycle it may.
  task automatic test_back_to_back();
    exp_t                        e;
    logic [N_CHARS*SYM_BITS-1:0] ch [2];
    logic [N_CHARS*LW-1:0]       ln [2];
    logic [CW-1:0]               cn [2];
    ch[0] = 6'b100_011; ln[0] = 4'b01_10; cn[0] = 2'd3;
    ch[1] = 6'b111_010; ln[1] = 4'b11_00; cn[1] = 2'd2;
    for (int r = 0; r < 2; r++) begin
      push_model(ch[r], ln[r], int'(cn[r]), 1);
      launch(ch[r], ln[r], cn[r]);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({buzzer, busy, done} !== {e.buz, e.busy, e.done} || (e.idx_chk && char_idx !== e.idx)) begin
          errors++;
          $display("FAIL back_to_back run=%0d cyc=%0d got buz/busy/done/idx=%b%b%b/%0d want %b%b%b/%0d", r, cyc, buzzer, busy, done, char_idx, e.buz, e.busy, e.done, e.idx);
        end
        tick();
      end
    end
  endtask

`ifdef MORSE_LOOP_EN
  task automatic test_loop();
    exp_t e;
    loop = 1'b1;
    push_model(BASIC_CH, BASIC_LN, 2, 2);
    launch(BASIC_CH, BASIC_LN, 2'd2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({buzzer, busy, done} !== {e.buz, e.busy, e.done} || (e.idx_chk && char_idx !== e.idx)) begin
        errors++;
        $display("FAIL loop cyc=%0d got buz/busy/done/idx=%b%b%b/%0d want %b%b%b/%0d", cyc, buzzer, busy, done, char_idx, e.buz, e.busy, e.done, e.idx);
      end
      if (cyc == 69) loop = 1'b0;
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    chars = '0;
    lens  = '0;
    count = '0;
`ifdef MORSE_LOOP_EN
    loop  = 1'b0;
`endif
    test_reset();
    test_basic();
    test_count_zero();
    test_latch_ignore();
    test_abort();
    test_back_to_back();
`ifdef MORSE_LOOP_EN
    test_loop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
